// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// a2d_pkg : shared types and constants for the ADC128S round-robin sampler
// Revision: 1.0
// ============================================================================
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    XFER1   = 3'd1,
    GAP     = 3'd2,
    XFER2   = 3'd3,
    CAPTURE = 3'd4
  } a2d_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SHIFT = 2'd1,
    SPI_BACK  = 2'd2,
    SPI_DONE  = 2'd3
  } spi_state_e;

  // SCLK runs at clk / 2**SCLK_DIV_W
  localparam int SCLK_DIV_W = 5;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  function automatic logic [2:0] rr_to_chnl(input logic [1:0] rr);
    logic [2:0] ch;
    case (rr)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      2'd2:    ch = CH_STEER;
      default: ch = CH_BATT;
    endcase
    return ch;
  endfunction

  function automatic logic [15:0] chnl_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mnrch.sv
`default_nettype none
// ============================================================================
// spi_mnrch : 16-bit SPI master, SCLK idle high, MOSI on fall, MISO on rise
// Revision: 1.0
// ============================================================================
module spi_mnrch
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {SCLK_DIV_W{1'b1}};

  spi_state_e            state_q, state_d;
  logic [SCLK_DIV_W-1:0] div_q, div_d;
  logic [4:0]            bit_q, bit_d;
  logic [15:0]           tx_q, tx_d;
  logic [15:0]           rx_q, rx_d;
  logic                  ss_n_q, ss_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SPI_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    case (state_q)
      SPI_IDLE: begin
        if (wrt) begin
          ss_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = cmd;
          state_d = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        div_d = div_q + SCLK_DIV_W'(1);
        if (div_q == DIV_FALL) begin
          sclk_d = 1'b0;
          mosi_d = tx_q[15];
          tx_d   = {tx_q[14:0], 1'b0};
        end
        if (div_q == DIV_RISE) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[14:0], MISO};
          bit_d  = bit_q + 5'd1;
          if (bit_q == 5'd15) state_d = SPI_BACK;
        end
      end
      // SS_n is released before done so the slave sees a clean frame end
      SPI_BACK: begin
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = SPI_DONE;
      end
      SPI_DONE: begin
        done_d  = 1'b1;
        state_d = SPI_IDLE;
      end
      default: state_d = SPI_IDLE;
    endcase
  end

  assign done    = done_q;
  assign rd_data = rx_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;

endmodule
`default_nettype wire

// File: rtl/a2d_round_robin.sv
`default_nettype none
// ============================================================================
// a2d_round_robin : cycles ADC128S channels 0/4/5/6 into four result registers
// Revision: 1.0
// ============================================================================
module a2d_round_robin
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  a2d_state_e  state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;
  logic        cnv_q, cnv_d;
  logic        busy_q, busy_d;

  logic        wrt;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic [15:0] spi_cmd;
  logic [3:0]  rd_hi_unused;

  assign spi_cmd      = chnl_cmd(rr_to_chnl(rr_q));
  assign rd_hi_unused = spi_rd_data[15:12];

  spi_mnrch u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (spi_cmd),
    .done    (spi_done),
    .rd_data (spi_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
      cnv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
      cnv_q   <= cnv_d;
      busy_q  <= busy_d;
    end
  end

  // The first frame only addresses the channel; the ADC returns that
  // channel's sample during the second frame.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    cnv_d   = 1'b0;
    busy_d  = busy_q;
    wrt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          wrt     = 1'b1;
          busy_d  = 1'b1;
          state_d = XFER1;
        end
      end
      XFER1: if (spi_done) state_d = GAP;
      GAP: begin
        wrt     = 1'b1;
        state_d = XFER2;
      end
      XFER2: if (spi_done) state_d = CAPTURE;
      CAPTURE: begin
        case (rr_q)
          2'd0:    lft_d   = spi_rd_data[11:0];
          2'd1:    rght_d  = spi_rd_data[11:0];
          2'd2:    steer_d = spi_rd_data[11:0];
          default: batt_d  = spi_rd_data[11:0];
        endcase
        cnv_d   = 1'b1;
        rr_d    = rr_q + 2'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cnv_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/a2d_round_robin.md
A2D_ROUND_ROBIN -- requirements
Module: a2d_round_robin

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, the block's only clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port nxt, input, 1 bit: single-clk pulse requesting the next channel conversion.
REQ-004 SHALL have ports lft_ld, rght_ld, steer_pot, batt, outputs, 12 bits each: latest results for channels 0, 4, 5, 6.
REQ-005 SHALL have port cnv_cmplt, output, 1 bit: one-clk pulse when a result register is updated.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion sequence is in progress.
REQ-007 SHALL have ports SS_n, SCLK and MOSI as outputs and MISO as input, 1 bit each: SPI to the ADC128S.

Function
REQ-008 SHALL keep a 2-bit round-robin index rr, mapped 0->ch0/lft_ld, 1->ch4/rght_ld, 2->ch5/steer_pot, 3->ch6/batt.
REQ-009 SHALL use an FSM with states IDLE, XFER1, GAP, XFER2, CAPTURE.
REQ-010 IDLE: on nxt, SHALL pulse SPI wrt with cmd {2'b00, chnl[2:0], 11'h000}, assert busy, and go to XFER1.
REQ-011 XFER1: on SPI done, SHALL go to GAP; the read data from this frame SHALL be discarded (it is the previous channel's data).
REQ-012 GAP: SHALL wait exactly 1 clk, then pulse wrt with the same cmd and go to XFER2.
REQ-013 XFER2: on done, SHALL go to CAPTURE.
REQ-014 CAPTURE (1 clk): SHALL load rd_data[11:0] into the register selected by rr, pulse cnv_cmplt, advance rr modulo 4 (3 wraps to 0), deassert busy, and return to IDLE.
REQ-015 A nxt arriving outside IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-016 A nxt arriving in the same clk as CAPTURE SHALL be ignored; it is honoured only from IDLE on the following clk.
REQ-017 Result registers not selected by rr SHALL hold their values; only one register updates per sequence.
REQ-018 SPI frame: SHALL be 16 bits, MSB first; SCLK period 32 clk, idle high; MOSI changes on SCLK fall; MISO sampled on SCLK rise; SS_n low for the whole frame.
REQ-019 Each SPI frame SHALL complete in at most 540 clk from wrt to done; a full nxt-to-cnv_cmplt sequence SHALL take at most 1085 clk.
REQ-020 SPI done SHALL be a 1-clk pulse issued after SS_n returns high.

Reset
REQ-021 On rst_n low, SHALL set state IDLE, rr=0, all four result registers to 12'h000, cnv_cmplt=0, busy=0, SS_n=1, SCLK=1, MOSI=0.
REQ-022 Reset asserted mid-frame SHALL immediately abort the frame (SS_n high) without any result update; after release, the block SHALL wait for a new nxt.

Structure
REQ-023 SHALL place the FSM state enum, the channel map constants (0, 4, 5, 6) and the SCLK divider width in a shared package, a2d_pkg.
REQ-024 SHALL instantiate one sub-module, spi_mnrch (16-bit SPI master: wrt, cmd, done, rd_data), which owns SS_n, SCLK, MOSI and MISO sampling.
REQ-025 SHALL make all outputs registered, with no combinational path from MISO to any output.

Verification
REQ-026 Bench SHALL cover: ADC model with ch0=12'h156, reset, one nxt -> exactly two SS_n frames, MOSI cmd 16'h0000 both times, lft_ld=12'h156, cnv_cmplt single pulse, rr=1.
REQ-027 Bench SHALL cover: four nxt pulses with ch4=12'h2A0, ch5=12'h800, ch6=12'hFFE -> rght_ld, steer_pot, batt updated in that order, MOSI cmds 16'h2000, 16'h2800, 16'h3000, rr wraps to 0.
REQ-028 Bench SHALL cover: fifth nxt with ch0 changed to 12'h3C0 -> only lft_ld changes to 12'h3C0; the other three registers are unchanged.
REQ-029 Bench SHALL cover: nxt pulsed every 100 clk while busy -> still exactly two frames per accepted nxt and no extra cnv_cmplt.
REQ-030 Bench SHALL cover: rst_n asserted during XFER2 -> SS_n=1 within the same cycle, all registers 0, and no cnv_cmplt; after release, a nxt restarts at ch0.
REQ-031 Bench SHALL cover: SCLK timing check -> period 32 clk, exactly 16 falling edges per frame, sequence latency of 1085 clk or less.
